// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single byte-addressed data memory.
// Optional misaligned-access trap for the data port: define MEM_ARB_ALIGN_CHECK_EN.
module mem_port_arbiter #(
   parameter int             ADDR_W   = 8,
   parameter int             MAX_WAIT = 2,
   parameter logic [2:0]     IF_FUNC3 = 3'b010
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_func3,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_done,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [2:0]        mem_func3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   state_t              state, state_nxt;
   logic                owner_d;
   logic [ADDR_W-1:0]   lat_addr;
   logic [2:0]          lat_func3;
   logic                lat_we;
   logic [31:0]         lat_wdata;
   logic                lat_mis;
   logic [3:0]          wait_cnt, wait_nxt;
   logic                grant_i, grant_d;
   logic                d_mis;

`ifdef MEM_ARB_ALIGN_CHECK_EN
   assign d_mis = ((d_func3[1:0] == 2'b01) && d_addr[0]) ||
                  ((d_func3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00));
`else
   assign d_mis = 1'b0;
`endif

   // Requests are only looked at in IDLE; D wins conflicts until wait_cnt hits MAX_WAIT.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && (!i_req || (wait_cnt < MAX_WAIT_C))) begin
               grant_d   = 1'b1;
               state_nxt = ACCESS;
               if (i_req) wait_nxt = wait_cnt + 4'd1;
            end else if (i_req) begin
               grant_i   = 1'b1;
               wait_nxt  = 4'd0;
               state_nxt = ACCESS;
            end
         end
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         owner_d   <= 1'b0;
         lat_addr  <= '0;
         lat_func3 <= 3'b000;
         lat_we    <= 1'b0;
         lat_wdata <= 32'h0;
         lat_mis   <= 1'b0;
         i_rdata   <= 32'h0;
         d_rdata   <= 32'h0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (grant_d) begin
            owner_d   <= 1'b1;
            lat_addr  <= d_addr;
            lat_func3 <= d_func3;
            lat_we    <= d_we;
            lat_wdata <= d_wdata;
            lat_mis   <= d_mis;
         end else if (grant_i) begin
            owner_d   <= 1'b0;
            lat_addr  <= i_addr;
            lat_func3 <= IF_FUNC3;
            lat_we    <= 1'b0;
            lat_wdata <= 32'h0;
            lat_mis   <= 1'b0;
         end
         // A trapped load returns zero instead of whatever the bus shows.
         if (state == ACCESS && !lat_we) begin
            if (owner_d) d_rdata <= lat_mis ? 32'h0 : mem_rdata;
            else         i_rdata <= mem_rdata;
         end
      end
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_func3 = 3'b000;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      if (state == ACCESS) begin
         mem_read  = !lat_we && !lat_mis;
         mem_write = lat_we && !lat_mis;
         mem_func3 = lat_func3;
         mem_addr  = lat_addr;
         mem_wdata = lat_we ? lat_wdata : 32'h0;
      end
   end

   assign i_done = (state == RESP) && !owner_d;
   assign d_done = (state == RESP) && owner_d;

`ifdef MEM_ARB_ALIGN_CHECK_EN
   assign d_err = d_done && lat_mis;
`else
   assign d_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte memory model, vector table, scoreboard of completions.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [7:0]  i_addr = 8'h0, d_addr = 8'h0;
   logic [2:0]  d_func3 = 3'b000;
   logic [31:0] d_wdata = 32'h0;
   logic        i_done, d_done, d_err, mem_read, mem_write;
   logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [2:0]  mem_func3;
   logic [7:0]  mem_addr;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_func3(mem_func3),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: preloaded while rst is high, combinational read, posedge write.
   logic [7:0] mem [0:255];
   logic [7:0] b0, b1, b2, b3;

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
         mem[0]  <= 8'd17;
         mem[16] <= 8'h78; mem[17] <= 8'h56; mem[18] <= 8'h34; mem[19] <= 8'h12;
         mem[20] <= 8'h01; mem[21] <= 8'h80;
      end else if (mem_write) begin
         mem[mem_addr] <= mem_wdata[7:0];
         if (mem_func3[1:0] != 2'b00) mem[mem_addr + 8'd1] <= mem_wdata[15:8];
         if (mem_func3[1]) begin
            mem[mem_addr + 8'd2] <= mem_wdata[23:16];
            mem[mem_addr + 8'd3] <= mem_wdata[31:24];
         end
      end
   end

   always_comb begin
      b0 = mem[mem_addr];
      b1 = mem[mem_addr + 8'd1];
      b2 = mem[mem_addr + 8'd2];
      b3 = mem[mem_addr + 8'd3];
      case (mem_func3)
         3'b000:  mem_rdata = {{24{b0[7]}}, b0};
         3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
         3'b100:  mem_rdata = {24'h0, b0};
         3'b101:  mem_rdata = {16'h0, b1, b0};
         default: mem_rdata = {b3, b2, b1, b0};
      endcase
   end

   typedef struct {
      logic        is_d;
      logic        we;
      logic [2:0]  func3;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      logic        mis;
   } vec_t;

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(logic is_d, logic we, logic [2:0] f3, logic [7:0] a,
                               logic [31:0] wd, logic [31:0] ex, logic mis);
      vec_t v;
      v.is_d = is_d; v.we = we; v.func3 = f3; v.addr = a;
      v.wdata = wd; v.exp = ex; v.mis = mis;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, want);
      end
   endtask

   task automatic push(input logic is_d, input logic [31:0] rd, input logic err);
      exp_t e;
      e.is_d = is_d; e.rdata = rd; e.err = err;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && (i_done || d_done)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got i_done=%b d_done=%b want no completion", i_done, d_done);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ((i_done && d_done) || (d_done !== e.is_d) ||
                ((e.is_d ? d_rdata : i_rdata) !== e.rdata) || (d_err !== e.err)) begin
               errors++;
               $display("FAIL sb_done got d=%b i=%b rdata=%h err=%b want d=%b rdata=%h err=%b",
                        d_done, i_done, e.is_d ? d_rdata : i_rdata, d_err, e.is_d, e.rdata, e.err);
            end
         end
      end
   end

   // One access: accept in IDLE, scramble inputs, check the bus in ACCESS and done in RESP.
   task automatic run(input vec_t t);
      @(posedge clk); #1;
      if (t.is_d) begin
         d_req = 1'b1; d_we = t.we; d_func3 = t.func3; d_addr = t.addr; d_wdata = t.wdata;
      end else begin
         i_req = 1'b1; i_addr = t.addr;
      end
      push(t.is_d, t.exp, t.mis);
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
      d_addr = 8'($urandom); d_wdata = $urandom; d_func3 = 3'($urandom);
      d_we = 1'($urandom); i_addr = 8'($urandom);
      @(negedge clk);
      chk("bus_ctl", {27'b0, mem_read, mem_write, mem_func3},
          {27'b0, !t.we && !t.mis, t.we && !t.mis, t.is_d ? t.func3 : 3'b010});
      chk("bus_addr", {24'b0, mem_addr}, {24'b0, t.addr});
      chk("bus_wdata", mem_wdata, t.we ? t.wdata : 32'h0);
      @(negedge clk);
      chk("done_lat", {30'b0, d_done, i_done}, t.is_d ? 32'd2 : 32'd1);
   endtask

   vec_t vecs[13];

   initial begin
      vecs[0]  = mk(0, 0, 3'b010, 8'd0,  32'h0,        32'd17,        0);
      vecs[1]  = mk(1, 1, 3'b010, 8'd4,  32'hDEADBEEF, 32'h00000000,  0);
      vecs[2]  = mk(1, 0, 3'b010, 8'd4,  32'h0,        32'hDEADBEEF,  0);
      vecs[3]  = mk(1, 1, 3'b000, 8'd8,  32'h00000080, 32'hDEADBEEF,  0);
      vecs[4]  = mk(1, 0, 3'b000, 8'd8,  32'h0,        32'hFFFFFF80,  0);
      vecs[5]  = mk(1, 0, 3'b100, 8'd8,  32'h0,        32'h00000080,  0);
      vecs[6]  = mk(1, 0, 3'b001, 8'd20, 32'h0,        32'hFFFF8001,  0);
      vecs[7]  = mk(1, 0, 3'b101, 8'd20, 32'h0,        32'h00008001,  0);
      vecs[8]  = mk(0, 0, 3'b010, 8'd16, 32'h0,        32'h12345678,  0);
      vecs[9]  = mk(1, 1, 3'b001, 8'd24, 32'hABCD1234, 32'h00008001,  0);
      vecs[10] = mk(1, 0, 3'b010, 8'd24, 32'h0,        32'h00001234,  0);
      vecs[11] = mk(0, 0, 3'b010, 8'd4,  32'h0,        32'hDEADBEEF,  0);
      vecs[12] = mk(1, 0, 3'b000, 8'd4,  32'h0,        32'hFFFFFFEF,  0);

      #2;
      chk("rst_ctl", {25'b0, i_done, d_done, d_err, mem_read, mem_write, mem_func3}, 32'h0);
      chk("rst_bus", {mem_addr, 24'b0} | mem_wdata, 32'h0);
      chk("rst_rdata", i_rdata | d_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int v = 0; v < 13; v++) begin
         run(vecs[v]);
         // d_rdata must survive the fetch that follows the lhu
         if (v == 8) chk("d_hold", d_rdata, 32'h00008001);
      end

      // Continuous conflict: D, D, I, D, D, I with completions 3 cycles apart.
      begin
         int n = 0, last = 0;
         push(1, 32'hDEADBEEF, 0); push(1, 32'hDEADBEEF, 0); push(0, 32'd17, 0);
         push(1, 32'hDEADBEEF, 0); push(1, 32'hDEADBEEF, 0); push(0, 32'd17, 0);
         @(posedge clk); #1;
         i_req = 1'b1; i_addr = 8'd0;
         d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b010; d_addr = 8'd4;
         for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (i_done || d_done) begin
               if (n > 0) chk("starve_gap", c - last, 32'd3);
               last = c;
               n++;
               if (n == 6) begin i_req = 1'b0; d_req = 1'b0; end
            end
         end
         chk("starve_cnt", n, 32'd6);
         i_req = 1'b0; d_req = 1'b0;
      end

`ifdef MEM_ARB_ALIGN_CHECK_EN
      run(mk(1, 0, 3'b010, 8'd2, 32'h0,        32'h0, 1));
      run(mk(1, 1, 3'b010, 8'd6, 32'h55555555, 32'h0, 1));
      chk("mis_store", {mem[6], mem[7], mem[8], mem[9]}, 32'hADDE8000);
`else
      run(mk(1, 0, 3'b010, 8'd2, 32'h0, 32'hBEEF0000, 0));
`endif

      // Reset in the middle of a store's ACCESS cycle.
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b1; d_func3 = 3'b010; d_addr = 8'd12; d_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      d_req = 1'b0;
      chk("rst_pre_wr", {31'b0, mem_write}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_ctl", {25'b0, i_done, d_done, d_err, mem_read, mem_write, mem_func3}, 32'h0);
      chk("rst_mid_bus", {mem_addr, 24'b0} | mem_wdata, 32'h0);
      chk("rst_mid_rdata", i_rdata | d_rdata, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_idle_bus", {30'b0, mem_read, mem_write}, 32'h0);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
